interval_timer_ctrl: RTL and testbench



---
 rtl/interval_timer_ctrl.sv | 102 ++++++++++
 tb/tb_interval_timer_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer for a free-running up-counter: one-shot, N-periodic
// or endless-periodic operation with per-period ticks and a completion pulse.
module interval_timer_ctrl #(
  parameter int BW     = 8,
  parameter int REP_BW = 4
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              mode_i,
  input  logic [BW-1:0]     period_i,
  input  logic [REP_BW-1:0] repeat_i,
  input  logic [BW-1:0]     cnt_i,
  output logic              cntClr_o,
  output logic              busy_o,
  output logic              tick_o,
  output logic              done_o,
  output logic [REP_BW-1:0] tickCnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [BW-1:0]     period_r;
  logic              mode_r;
  logic [REP_BW-1:0] repeat_r;
  logic [REP_BW-1:0] tick_cnt_r;
  logic [REP_BW-1:0] tick_inc_s;
  logic              run_s;
  logic              term_s;
  logic              tick_s;
  logic              last_s;

  // >= rather than == so a counter that overshoots still terminates the period
  assign run_s      = (state_r == ST_RUN);
  assign term_s     = run_s && (cnt_i >= period_r);
  assign tick_s     = term_s && !stop_i;
  assign tick_inc_s = tick_cnt_r + {{(REP_BW-1){1'b0}}, 1'b1};
  assign last_s     = !mode_r || ((repeat_r != {REP_BW{1'b0}}) && (tick_inc_s == repeat_r));

  assign busy_o    = run_s;
  assign tick_o    = tick_s;
  assign cntClr_o  = run_s && !term_s && !stop_i;
  assign done_o    = (state_r == ST_DONE);
  assign tickCnt_o = tick_cnt_r;

  // Next-state selection; stop wins over tick in RUN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_nxt_s = ST_IDLE;
        end else if (tick_s && last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Configuration latched only on an accepted start; tick count runs in RUN
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      period_r   <= {BW{1'b0}};
      mode_r     <= 1'b0;
      repeat_r   <= {REP_BW{1'b0}};
      tick_cnt_r <= {REP_BW{1'b0}};
    end else if ((state_r == ST_IDLE) && start_i && !stop_i) begin
      period_r   <= period_i;
      mode_r     <= mode_i;
      repeat_r   <= repeat_i;
      tick_cnt_r <= {REP_BW{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= tick_inc_s;
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Bench for interval_timer_ctrl: a behavioural up-counter feeds cnt_i, and a
// model based on elapsed RUN cycles predicts every output each cycle.
module tb_interval_timer_ctrl;
  localparam int BW = 8;
  localparam int RB = 4;

  logic          clk_i = 1'b0;
  logic          nrst_i;
  logic          start_i, stop_i, mode_i;
  logic [BW-1:0] period_i, cnt;
  logic [RB-1:0] repeat_i, tickCnt_o;
  logic          cntClr_o, busy_o, tick_o, done_o;

  int m_st, m_e, m_p, m_mode, m_rep, m_ticks;
  int cyc, n_pass, n_checks, tick_cyc, done_cyc, s;

  always #5 clk_i = ~clk_i;

  interval_timer_ctrl #(.BW(BW), .REP_BW(RB)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .start_i(start_i), .stop_i(stop_i),
    .mode_i(mode_i), .period_i(period_i), .repeat_i(repeat_i), .cnt_i(cnt),
    .cntClr_o(cntClr_o), .busy_o(busy_o), .tick_o(tick_o), .done_o(done_o),
    .tickCnt_o(tickCnt_o)
  );

  // The counter being sequenced
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) cnt <= '0;
    else if (!cntClr_o) cnt <= '0;
    else cnt <= cnt + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_e = 0; m_p = 0; m_mode = 0; m_rep = 0; m_ticks = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge
  task automatic step();
    bit et;
    @(negedge clk_i);
    et = (m_st == 1) && ((m_e % (m_p + 1)) == m_p);
    chk("busy", busy_o, m_st == 1);
    chk("tick", tick_o, et && !stop_i);
    chk("cntclr", cntClr_o, (m_st == 1) && !et && !stop_i);
    chk("done", done_o, m_st == 2);
    chk("tickcnt", tickCnt_o, m_ticks);
    if (tick_o === 1'b1) tick_cyc = cyc;
    if (done_o === 1'b1) done_cyc = cyc;
    @(posedge clk_i);
    case (m_st)
      0: if (start_i && !stop_i) begin
        m_st = 1; m_p = period_i; m_mode = mode_i; m_rep = repeat_i; m_ticks = 0; m_e = 0;
      end
      1: if (stop_i) m_st = 0;
         else begin
           if (et) begin
             m_ticks = (m_ticks + 1) % 16;
             if (m_mode == 0 || (m_rep != 0 && m_ticks == m_rep)) m_st = 2;
           end
           m_e++;
         end
      default: m_st = 0;
    endcase
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic go(input logic md, input int p, input int r);
    mode_i = md; period_i = BW'(p); repeat_i = RB'(r); start_i = 1'b1;
    s = cyc;
    step();
    start_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_tick"}, tick_o, 0);
    chk({tag, "_cntclr"}, cntClr_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_tickcnt"}, tickCnt_o, 0);
  endtask

  initial begin
    n_pass = 0; n_checks = 0; cyc = 0; tick_cyc = -1; done_cyc = -1;
    nrst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; mode_i = 1'b0;
    period_i = '0; repeat_i = '0;
    model_reset();
    #12;
    chk_zero("reset");
    @(posedge clk_i); #1;
    nrst_i = 1'b1;

    // One-shot, period 4
    go(1'b0, 4, 0);
    run(8);
    chk("s1_tick_lat", tick_cyc - s, 5);
    chk("s1_done_lat", done_cyc - s, 6);
    chk("s1_tickcnt", tickCnt_o, 1);

    // Periodic, 3 repeats of period 2
    go(1'b1, 2, 3);
    run(12);
    chk("s2_last_tick", tick_cyc - s, 9);
    chk("s2_done_lat", done_cyc - s, 10);
    chk("s2_tickcnt", tickCnt_o, 3);

    // Endless, period 0: 19 ticks wraps the 4-bit count to 3
    go(1'b1, 0, 0);
    run(19);
    chk("s3_wrap", tickCnt_o, 3);
    stop_i = 1'b1; step(); stop_i = 1'b0;
    run(3);
    chk("s3_nodone", done_cyc < s, 1);

    // Stop coinciding with a tick
    go(1'b1, 5, 0);
    run(5);
    stop_i = 1'b1; step(); stop_i = 1'b0;
    run(2);
    chk("s4_tickcnt", tickCnt_o, 0);
    chk("s4_busy", busy_o, 0);

    // Start and period change during RUN are ignored
    go(1'b1, 5, 0);
    run(3);
    start_i = 1'b1; period_i = 8'd1; step(); start_i = 1'b0;
    run(15);
    chk("s5_spacing", tick_cyc - s, 18);
    chk("s5_tickcnt", tickCnt_o, 3);
    stop_i = 1'b1; step(); stop_i = 1'b0;

    // Asynchronous reset mid-RUN
    go(1'b1, 9, 0);
    run(3);
    chk("s6_cnt", cnt, 3);
    #2 nrst_i = 1'b0;
    #1 chk_zero("s6_reset");
    model_reset();
    @(posedge clk_i); #1;
    nrst_i = 1'b1;
    go(1'b0, 4, 0);
    run(8);
    chk("s6_tick_lat", tick_cyc - s, 5);
    chk("s6_done_lat", done_cyc - s, 6);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      start_i  = ($urandom_range(0, 3) == 0);
      stop_i   = ($urandom_range(0, 19) == 0);
      mode_i   = 1'($urandom_range(0, 1));
      period_i = BW'($urandom_range(0, 6));
      repeat_i = RB'($urandom_range(0, 4));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
